// File: rtl/select_arbiter.sv
// rtl/select_arbiter.sv - round-robin arbiter sequencing a shared select-driven datapath
//
// Grants one of NUM_REQ requesters at a time and drives the shared mux select.
// Every change of owner passes through a one-cycle RELEASE gap so the mux select
// never moves underneath an active grant.
//
// Optional feature macro: SELECT_ARB_TIMEOUT_EN
//   defined   - an owner holding its request for MAX_HOLD grant cycles is revoked
//               and timeout_pulse fires for one cycle
//   undefined - grant held until the owner drops req; timeout_pulse tied to 0
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active-high
//   req           in   [NUM_REQ-1:0] request levels, bit i = requester i
//   grant         out  [NUM_REQ-1:0] one-hot grant, registered
//   sel           out  [SEL_W-1:0] current or last owner index, registered
//   valid         out  high while any grant is active, registered
//   timeout_pulse out  one-cycle pulse on forced revoke, registered

module select_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               valid,
    output logic               timeout_pulse
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
        $error("select_arbiter: parameter out of range");
    end

    logic [1:0]         state;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   win;
    logic               win_found;
    logic [SEL_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] win_onehot;
    logic               owner_req;
    int                 idx;

    // Rotating priority search starting at ptr. Walking the offsets from the
    // far end back to zero lets the closest requester overwrite the others.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx[SEL_W-1:0]]) begin
                win       = idx[SEL_W-1:0];
                win_found = 1'b1;
            end
        end
    end

    assign ptr_next   = (win == SEL_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
    assign owner_req  = req[sel];

`ifdef SELECT_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            grant         <= '0;
            sel           <= '0;
            valid         <= 1'b0;
            timeout_pulse <= 1'b0;
            hold_cnt      <= 8'd0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant    <= win_onehot;
                        sel      <= win;
                        valid    <= 1'b1;
                        ptr      <= ptr_next;
                        hold_cnt <= 8'd1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // A voluntary drop on the limit cycle wins over the timeout.
                    if (!owner_req) begin
                        grant <= '0;
                        valid <= 1'b0;
                        state <= RELEASE;
                    end else if (hold_cnt == 8'(MAX_HOLD)) begin
                        grant         <= '0;
                        valid         <= 1'b0;
                        timeout_pulse <= 1'b1;
                        state         <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign timeout_pulse = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            sel   <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant <= win_onehot;
                        sel   <= win;
                        valid <= 1'b1;
                        ptr   <= ptr_next;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        grant <= '0;
                        valid <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_select_arbiter.sv
// tb/tb_select_arbiter.sv - self-checking bench for select_arbiter

module tb_select_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       timeout_pulse;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
        logic       tp;
    } row_t;

    row_t exp_q[$];

    select_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .grant         (grant),
        .sel           (sel),
        .valid         (valid),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(logic [3:0] r, logic [3:0] g, logic [1:0] s, logic v, logic t);
        row_t x;
        x.req = r; x.grant = g; x.sel = s; x.valid = v; x.tp = t;
        return x;
    endfunction

    task automatic pulse_reset();
        req = 4'b0000;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        row_t rows[$];
        row_t e;
        for (int i = 0; i < 3; i++) rows.push_back(mk(4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) rows.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            rst = (i < 3);
            req = rows[i].req;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (grant !== e.grant) $display("FAIL reset[%0d] grant: got %b want %b", i, grant, e.grant); else passed++;
            checks++; if (sel !== e.sel) $display("FAIL reset[%0d] sel: got %0d want %0d", i, sel, e.sel); else passed++;
            checks++; if (valid !== e.valid) $display("FAIL reset[%0d] valid: got %b want %b", i, valid, e.valid); else passed++;
            checks++; if (timeout_pulse !== e.tp) $display("FAIL reset[%0d] timeout_pulse: got %b want %b", i, timeout_pulse, e.tp); else passed++;
        end
        rst = 1'b0;
    endtask

    // Requester 2 alone; leaves ptr at 3, which test_wrap_skip relies on.
    task automatic test_single();
        row_t rows[$];
        row_t e;
        for (int i = 0; i < 4; i++) rows.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0));
        rows.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0));
        rows.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0));
        foreach (rows[i]) begin
            req = rows[i].req;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (grant !== e.grant) $display("FAIL single[%0d] grant: got %b want %b", i, grant, e.grant); else passed++;
            checks++; if (sel !== e.sel) $display("FAIL single[%0d] sel: got %0d want %0d", i, sel, e.sel); else passed++;
            checks++; if (valid !== e.valid) $display("FAIL single[%0d] valid: got %b want %b", i, valid, e.valid); else passed++;
            checks++; if (timeout_pulse !== e.tp) $display("FAIL single[%0d] timeout_pulse: got %b want %b", i, timeout_pulse, e.tp); else passed++;
        end
    endtask

    // ptr=3 with req=0011: search wraps past 3 to 0, then 1 wins next.
    task automatic test_wrap_skip();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0));
        rows.push_back(mk(4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0));
        rows.push_back(mk(4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0));
        rows.push_back(mk(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
        rows.push_back(mk(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0));
        rows.push_back(mk(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0));
        foreach (rows[i]) begin
            req = rows[i].req;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (grant !== e.grant) $display("FAIL wrap[%0d] grant: got %b want %b", i, grant, e.grant); else passed++;
            checks++; if (sel !== e.sel) $display("FAIL wrap[%0d] sel: got %0d want %0d", i, sel, e.sel); else passed++;
            checks++; if (valid !== e.valid) $display("FAIL wrap[%0d] valid: got %b want %b", i, valid, e.valid); else passed++;
        end
    endtask

    // All four request constantly; each owner drops for one cycle after 3 grant cycles.
    task automatic test_round_robin();
        row_t rows[$];
        row_t e;
        logic [3:0] oh;
        pulse_reset();
        for (int n = 0; n < 5; n++) begin
            oh = 4'b0001 << (n % 4);
            for (int c = 0; c < 3; c++) rows.push_back(mk(4'b1111, oh, 2'(n % 4), 1'b1, 1'b0));
            rows.push_back(mk(4'b1111 & ~oh, 4'b0000, 2'(n % 4), 1'b0, 1'b0));
            rows.push_back(mk(4'b1111, 4'b0000, 2'(n % 4), 1'b0, 1'b0));
        end
        foreach (rows[i]) begin
            req = rows[i].req;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (grant !== e.grant) $display("FAIL rr[%0d] grant: got %b want %b", i, grant, e.grant); else passed++;
            checks++; if (sel !== e.sel) $display("FAIL rr[%0d] sel: got %0d want %0d", i, sel, e.sel); else passed++;
            checks++; if (valid !== e.valid) $display("FAIL rr[%0d] valid: got %b want %b", i, valid, e.valid); else passed++;
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        row_t e;
        pulse_reset();
`ifdef SELECT_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) rows.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0));
        rows.push_back(mk(4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1));
        rows.push_back(mk(4'b0011, 4'b0000, 2'd0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) rows.push_back(mk(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0));
        // owner drops exactly on the limit cycle: ordinary release, no pulse
        rows.push_back(mk(4'b0001, 4'b0000, 2'd1, 1'b0, 1'b0));
        rows.push_back(mk(4'b0001, 4'b0000, 2'd1, 1'b0, 1'b0));
        rows.push_back(mk(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0));
`else
        for (int i = 0; i < 12; i++) rows.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0));
`endif
        rows.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        rows.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        foreach (rows[i]) begin
            req = rows[i].req;
            exp_q.push_back(rows[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (grant !== e.grant) $display("FAIL timeout[%0d] grant: got %b want %b", i, grant, e.grant); else passed++;
            checks++; if (sel !== e.sel) $display("FAIL timeout[%0d] sel: got %0d want %0d", i, sel, e.sel); else passed++;
            checks++; if (valid !== e.valid) $display("FAIL timeout[%0d] valid: got %b want %b", i, valid, e.valid); else passed++;
            checks++; if (timeout_pulse !== e.tp) $display("FAIL timeout[%0d] timeout_pulse: got %b want %b", i, timeout_pulse, e.tp); else passed++;
        end
    endtask

    task automatic test_reset_mid_grant();
        row_t e;
        pulse_reset();
        for (int i = 0; i < 2; i++) begin
            req = 4'b1000;
            exp_q.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (grant !== e.grant) $display("FAIL midrst_pre[%0d] grant: got %b want %b", i, grant, e.grant); else passed++;
            checks++; if (sel !== e.sel) $display("FAIL midrst_pre[%0d] sel: got %0d want %0d", i, sel, e.sel); else passed++;
        end
        // assert reset between edges; outputs must clear without waiting for clk
        exp_q.push_back(mk(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0));
        rst = 1'b1;
        #2;
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant) $display("FAIL midrst_async grant: got %b want %b", grant, e.grant); else passed++;
        checks++; if (valid !== e.valid) $display("FAIL midrst_async valid: got %b want %b", valid, e.valid); else passed++;
        checks++; if (sel !== e.sel) $display("FAIL midrst_async sel: got %0d want %0d", sel, e.sel); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant) $display("FAIL midrst_post grant: got %b want %b", grant, e.grant); else passed++;
        checks++; if (sel !== e.sel) $display("FAIL midrst_post sel: got %0d want %0d", sel, e.sel); else passed++;
        checks++; if (valid !== e.valid) $display("FAIL midrst_post valid: got %b want %b", valid, e.valid); else passed++;
        req = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        #1;
        test_reset();
        test_single();
        test_wrap_skip();
        test_round_robin();
        test_timeout();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/select_arbiter.md
Name: select_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared select-driven datapath, such as a mux whose select comes from a small FSM.
- Grants exactly one of NUM_REQ requesters and drives the shared path's select index.
- Guarantees a one-cycle dead gap between owners so the downstream mux never switches under an active grant.
- Sits between requesting clients and the shared mux/resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- SEL_W, $clog2(NUM_REQ), select index width. Derived; do not override.
- MAX_HOLD, 16, maximum consecutive grant cycles per owner. Used only when the timeout feature is compiled in; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  NUM_REQ  per-requester request level; bit i = requester i.
- grant  output  NUM_REQ  one-hot grant, registered.
- sel  output  SEL_W  index of current or last owner, drives the shared mux select, registered.
- valid  output  1  high while any grant is active, registered.
- timeout_pulse  output  1  one-cycle pulse when a grant is forcibly revoked, registered.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values (asserted asynchronously, even mid-grant): grant=0, sel=0, valid=0, timeout_pulse=0, rr pointer ptr=0, hold counter=0, state=IDLE.
- All outputs are registered. No combinational path from req to any output.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner w = first set bit of req searching ptr, ptr+1, ... with wrap modulo NUM_REQ.
  - Next edge: grant=onehot(w), sel=w, valid=1, ptr=(w+1) mod NUM_REQ, counter=1, go to GRANT.
  - Latency from req sampled high in IDLE to grant visible: 1 cycle.
- GRANT:
  - While req[sel]=1, hold the grant.
  - When req[sel]=0 is sampled, next edge: grant=0, valid=0, go to RELEASE.
  - Requests from other requesters never preempt the owner.
- RELEASE:
  - Exactly one dead cycle: grant=0, valid=0.
  - sel keeps the previous owner's value so the mux is stable.
  - Unconditionally return to IDLE. Arbitration resumes in the IDLE cycle.
  - Minimum gap between two owners' grants: 2 cycles.
- sel changes only on the edge that asserts a new grant. It never changes while valid=0 except at reset.
- Pointer wrap: ptr=NUM_REQ-1 winning sets ptr=0.
- A requester that re-requests immediately after release is lowest priority relative to others.
- If req drops in IDLE on the same cycle it would be sampled, no grant is issued.
- Invariants: grant is always one-hot or zero, and valid == |grant.

Optional Feature:
- Macro: SELECT_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter increments each GRANT cycle.
  - If req[sel] is still 1 when counter==MAX_HOLD, next edge: grant=0, valid=0, timeout_pulse=1 (one cycle), go to RELEASE.
  - Grant is therefore high for exactly MAX_HOLD cycles max.
  - ptr has already advanced, so a different pending requester wins next.
  - If req[sel] drops in the same cycle counter==MAX_HOLD, this is a normal release: timeout_pulse=0.
- Not defined:
  - No counter is present, and the grant is held until the owner's req drops.
  - timeout_pulse is tied to 0.
  - MAX_HOLD is ignored.

Test Plan:
- Reset and idle: rst=1 for 3 cycles with req=4'b1111 → grant=0, sel=0, valid=0. Release rst with req=0 for 5 cycles → outputs stay 0.
- Single requester: req=4'b0100 held 4 cycles, then 0.
  - grant=4'b0100 and sel=2 one cycle after req rises, for 4 cycles.
  - Then 1 cycle RELEASE with grant=0, sel=2, and ptr=3.
- Round-robin fairness: req=4'b1111 constant, each owner dropping req for one cycle after 3 grant cycles.
  - Grant order is 0,1,2,3,0.
  - Every handover has ≥2 cycles with valid=0.
- Wrap and skip: ptr=3, req=4'b0011 → grant 0 first, then 1.
- Timeout (macro defined, MAX_HOLD=4): req=4'b0011 constant.
  - grant=4'b0001 for exactly 4 cycles, then timeout_pulse=1 with grant=0.
  - Then grant=4'b0010.
  - Without the macro, grant=4'b0001 is held indefinitely and timeout_pulse stays 0.
- Reset mid-grant: assert rst asynchronously (between edges) while grant=4'b1000 → grant=0 and valid=0 immediately. After release, with req=4'b1000 still high, the next grant goes to requester 3 (ptr=0 search).
